// File: rtl/anthem_pkg.sv
// Shared definitions for the volcano-name text streamer and checker:
// FSM states, expected text and the lookup helper.
package anthem_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCheck,
      StDone,
      StFail
   } chk_state_e;

   localparam int unsigned EXP_LEN    = 51;
   localparam int unsigned IDX_W      = $clog2(EXP_LEN);
   localparam logic [7:0]  SPACE_CHAR = 8'h20;

   // The first character lands in the most significant element.
   localparam logic [EXP_LEN-1:0][7:0] EXP_TEXT =
      "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";

   function automatic logic [7:0] exp_byte(input logic [7:0] idx);
      logic [IDX_W-1:0] pos;
      if (32'(idx) < EXP_LEN) begin
         pos = IDX_W'(EXP_LEN - 1 - 32'(idx));
         return EXP_TEXT[pos];
      end
      return 8'h00;
   endfunction

endpackage

// File: rtl/anthem_rom.sv
// Combinational lookup of the expected text; returns 0x00 past the end.
module anthem_rom
   import anthem_pkg::*;
(
   input  logic [7:0] idx,
   output logic [7:0] data
);

   always_comb begin
      data = exp_byte(idx);
   end

endmodule

// File: rtl/text_stream_checker.sv
// Receive-side checker: compares an incoming ASCII stream against the expected
// volcano text and reports progress plus sticky pass/fail status.
module text_stream_checker
   import anthem_pkg::*;
#(
   parameter int unsigned EXP_LEN = anthem_pkg::EXP_LEN,
   parameter bit          RESYNC  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       start,
   output logic [7:0] byte_idx,
   output logic [3:0] word_count,
   output logic       word_done,
   output logic       pass,
   output logic       fail,
   output logic [7:0] fail_idx,
   output logic [7:0] fail_byte,
   output logic       busy
);

   localparam logic [7:0] LastIdx  = 8'(EXP_LEN - 1);
   localparam logic [7:0] SyncChar = exp_byte(8'd0);

   chk_state_e st_q, st_d;
   logic [7:0] byte_idx_q, byte_idx_d;
   logic [3:0] word_count_q, word_count_d;
   logic       word_done_q, word_done_d;
   logic       pass_q, pass_d;
   logic       fail_q, fail_d;
   logic [7:0] fail_idx_q, fail_idx_d;
   logic [7:0] fail_byte_q, fail_byte_d;
   logic       busy_q, busy_d;
   logic [7:0] exp_data;

   anthem_rom u_rom (
      .idx  (byte_idx_q),
      .data (exp_data)
   );

   always_comb begin
      st_d         = st_q;
      byte_idx_d   = byte_idx_q;
      word_count_d = word_count_q;
      word_done_d  = 1'b0;
      pass_d       = pass_q;
      fail_d       = fail_q;
      fail_idx_d   = fail_idx_q;
      fail_byte_d  = fail_byte_q;

      if (start) begin
         // Restart wins over any byte arriving in the same cycle.
         st_d         = StIdle;
         byte_idx_d   = 8'd0;
         word_count_d = 4'd0;
         pass_d       = 1'b0;
         fail_d       = 1'b0;
         fail_idx_d   = 8'd0;
         fail_byte_d  = 8'd0;
      end else begin
         unique case (st_q)
            StIdle: begin
               if (rx_valid && rx_data == SyncChar) begin
                  st_d       = StCheck;
                  byte_idx_d = 8'd1;
               end
            end
            StCheck: begin
               if (rx_valid) begin
                  if (rx_data == exp_data) begin
                     byte_idx_d = byte_idx_q + 8'd1;
                     if (rx_data == SPACE_CHAR) begin
                        word_done_d = 1'b1;
                        if (word_count_q != 4'hf) begin
                           word_count_d = word_count_q + 4'd1;
                        end
                     end
                     if (byte_idx_q == LastIdx) begin
                        st_d   = StDone;
                        pass_d = 1'b1;
                     end
                  end else begin
                     st_d   = StFail;
                     fail_d = 1'b1;
                     // Only the first mismatch is recorded across resyncs.
                     if (!fail_q) begin
                        fail_idx_d  = byte_idx_q;
                        fail_byte_d = rx_data;
                     end
                  end
               end
            end
            StDone: begin
            end
            StFail: begin
               if (RESYNC && rx_valid && rx_data == SyncChar) begin
                  st_d         = StCheck;
                  byte_idx_d   = 8'd1;
                  word_count_d = 4'd0;
               end
            end
            default: st_d = StIdle;
         endcase
      end

      busy_d = (st_d == StCheck);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= StIdle;
         byte_idx_q   <= 8'd0;
         word_count_q <= 4'd0;
         word_done_q  <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         fail_idx_q   <= 8'd0;
         fail_byte_q  <= 8'd0;
         busy_q       <= 1'b0;
      end else begin
         st_q         <= st_d;
         byte_idx_q   <= byte_idx_d;
         word_count_q <= word_count_d;
         word_done_q  <= word_done_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         fail_idx_q   <= fail_idx_d;
         fail_byte_q  <= fail_byte_d;
         busy_q       <= busy_d;
      end
   end

   assign byte_idx   = byte_idx_q;
   assign word_count = word_count_q;
   assign word_done  = word_done_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign fail_idx   = fail_idx_q;
   assign fail_byte  = fail_byte_q;
   assign busy       = busy_q;

endmodule
